sprite_pos_controller: RTL and testbench

- Decodes the PS/2 scan-code byte stream into held/released state for the four arrow keys.
- Once per video frame, moves the on-screen sprite or rectangle origin by a fixed step, then clamps (or wraps) it to the visible area.
- Sits between the PS/2 receiver and the VGA pixel/ROM-address control path, which consumes Pos_X/Pos_Y as the sprite origin.
- Replaces per-clock position updates with frame-synchronous, press/release-aware motion.

---
 rtl/sprite_pos_controller.sv | 119 +++++++++++
 tb/tb_sprite_pos_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pos_controller.sv
// PS/2 arrow-key decoder driving frame-synchronous sprite motion with clamped limits.
// Define SPRITE_WRAP_EN to wrap around the visible area instead of clamping.
module sprite_pos_controller #(
  parameter int STEP   = 4,
  parameter int X_MAX  = 1390,
  parameter int Y_MAX  = 850,
  parameter int X_INIT = 400,
  parameter int Y_INIT = 400
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Frame_Start,
  input  logic        Scan_Valid,
  input  logic [7:0]  Scan_Code,
  output logic [10:0] Pos_X,
  output logic [10:0] Pos_Y,
  output logic        Pos_Update,
  output logic [3:0]  Key_State
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  key_nxt;
  logic [3:0]  arrow;
  logic [10:0] x_nxt, y_nxt;

  // One axis step in 12 bits: bit 11 flags underflow before clamp/wrap.
  function automatic logic [10:0] axis_next(input logic [10:0] pos, input logic dec,
                                            input logic inc, input logic [11:0] lim);
    logic [11:0] lo, hi;
    lo = {1'b0, pos} - 12'(STEP);
    hi = {1'b0, pos} + 12'(STEP);
    axis_next = pos;
    if (dec && !inc) begin
      if (lo[11])
`ifdef SPRITE_WRAP_EN
        axis_next = 11'(lo + lim + 12'd1);
`else
        axis_next = '0;
`endif
      else
        axis_next = lo[10:0];
    end else if (inc && !dec) begin
      if (hi > lim)
`ifdef SPRITE_WRAP_EN
        axis_next = 11'(hi - lim - 12'd1);
`else
        axis_next = lim[10:0];
`endif
      else
        axis_next = hi[10:0];
    end
  endfunction

  always_comb begin
    arrow = '0;
    case (Scan_Code)
      8'h75:   arrow = 4'b0001;
      8'h72:   arrow = 4'b0010;
      8'h6B:   arrow = 4'b0100;
      8'h74:   arrow = 4'b1000;
      default: arrow = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = Key_State;
    if (Scan_Valid) begin
      case (state)
        S_IDLE: begin
          if (Scan_Code == 8'hE0)      state_nxt = S_EXT;
          else if (Scan_Code == 8'hF0) state_nxt = S_BRK;
        end
        S_EXT: begin
          if (Scan_Code == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else begin
            state_nxt = S_IDLE;
            key_nxt   = Key_State | arrow;
          end
        end
        S_BRK: state_nxt = S_IDLE;
        S_EXT_BRK: begin
          state_nxt = S_IDLE;
          key_nxt   = Key_State & ~arrow;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    x_nxt = axis_next(Pos_X, Key_State[2], Key_State[3], 12'(X_MAX));
    y_nxt = axis_next(Pos_Y, Key_State[0], Key_State[1], 12'(Y_MAX));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      Key_State  <= '0;
      Pos_X      <= 11'(X_INIT);
      Pos_Y      <= 11'(Y_INIT);
      Pos_Update <= 1'b0;
    end else begin
      state     <= state_nxt;
      Key_State <= key_nxt;
      if (Frame_Start) begin
        Pos_X      <= x_nxt;
        Pos_Y      <= y_nxt;
        Pos_Update <= (x_nxt != Pos_X) || (y_nxt != Pos_Y);
      end else begin
        Pos_Update <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_pos_controller.sv
// Randomized self-checking bench for sprite_pos_controller against a key/position model.
`timescale 1ns/1ps
module tb_sprite_pos_controller;
  localparam int STEP  = 4;
  localparam int X_MAX = 1390;
  localparam int Y_MAX = 850;
  localparam int BX_INIT = 2;
  localparam int BY_INIT = 848;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Frame_Start = 1'b0;
  logic        Scan_Valid = 1'b0;
  logic [7:0]  Scan_Code = '0;
  logic [10:0] a_x, a_y, b_x, b_y;
  logic        a_upd, b_upd;
  logic [3:0]  a_keys, b_keys;

  sprite_pos_controller #(.STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
                          .X_INIT(400), .Y_INIT(400)) dut_a (
    .CLK(CLK), .RST(RST), .Frame_Start(Frame_Start), .Scan_Valid(Scan_Valid),
    .Scan_Code(Scan_Code), .Pos_X(a_x), .Pos_Y(a_y), .Pos_Update(a_upd), .Key_State(a_keys));

  sprite_pos_controller #(.STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
                          .X_INIT(BX_INIT), .Y_INIT(BY_INIT)) dut_b (
    .CLK(CLK), .RST(RST), .Frame_Start(Frame_Start), .Scan_Valid(Scan_Valid),
    .Scan_Code(Scan_Code), .Pos_X(b_x), .Pos_Y(b_y), .Pos_Update(b_upd), .Key_State(b_keys));

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_keys;
  int m_ax, m_ay, m_bx, m_by;
  logic [7:0] arrow_code [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference motion: move, then clamp or wrap into [0, mx].
  function automatic int axis_model(int p, bit dec, bit inc, int mx);
    int n = p;
    if (dec && !inc)      n = p - STEP;
    else if (inc && !dec) n = p + STEP;
`ifdef SPRITE_WRAP_EN
    if (n < 0)       n = n + mx + 1;
    else if (n > mx) n = n - (mx + 1);
`else
    if (n < 0)       n = 0;
    else if (n > mx) n = mx;
`endif
    return n;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    Scan_Valid = 1'b1;
    Scan_Code  = b;
    tick();
    Scan_Valid = 1'b0;
    Scan_Code  = 8'($urandom);
  endtask

  task automatic check_keys(input string tag);
    check({tag, "/keys_a"}, a_keys, m_keys);
    check({tag, "/keys_b"}, b_keys, m_keys);
  endtask

  task automatic model_reset();
    m_keys = '0;
    m_ax = 400; m_ay = 400; m_bx = BX_INIT; m_by = BY_INIT;
  endtask

  task automatic press(input int k);
    send_byte(8'hE0);
    send_byte(arrow_code[k]);
    m_keys[k] = 1'b1;
    check_keys("press");
  endtask

  task automatic release_key(input int k);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(arrow_code[k]);
    m_keys[k] = 1'b0;
    check_keys("release");
  endtask

  task automatic bare_release(input int k);
    send_byte(8'hF0);
    send_byte(arrow_code[k]);
    check_keys("bare_release");
  endtask

  task automatic check_frame(input int nax, input int nay, input int nbx, input int nby);
    check("frame/ax", a_x, nax);
    check("frame/ay", a_y, nay);
    check("frame/bx", b_x, nbx);
    check("frame/by", b_y, nby);
    check("frame/upd_a", a_upd, (nax != m_ax) || (nay != m_ay));
    check("frame/upd_b", b_upd, (nbx != m_bx) || (nby != m_by));
    m_ax = nax; m_ay = nay; m_bx = nbx; m_by = nby;
  endtask

  task automatic frame();
    int nax, nay, nbx, nby;
    nax = axis_model(m_ax, m_keys[2], m_keys[3], X_MAX);
    nay = axis_model(m_ay, m_keys[0], m_keys[1], Y_MAX);
    nbx = axis_model(m_bx, m_keys[2], m_keys[3], X_MAX);
    nby = axis_model(m_by, m_keys[0], m_keys[1], Y_MAX);
    Frame_Start = 1'b1;
    tick();
    Frame_Start = 1'b0;
    check_frame(nax, nay, nbx, nby);
    tick();
    check("frame/upd_a_drop", a_upd, 1'b0);
    check("frame/upd_b_drop", b_upd, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nax, nay, nbx, nby;
    logic [7:0] c;
    model_reset();
    tick();
    tick();
    check("reset/ax", a_x, 400);
    check("reset/ay", a_y, 400);
    check("reset/upd", a_upd, 1'b0);
    check_keys("reset");
    RST = 1'b0;
    tick();
    check("post_reset/bx", b_x, BX_INIT);

    // Press and hold up, then release.
    press(0);
    repeat (3) frame();
    release_key(0);
    frame();
    press(0);
    bare_release(0);
    release_key(0);

    // Left held into the lower limit and beyond.
    press(2);
    repeat (102) frame();
    release_key(2);

    // Opposing keys, then diagonal and the upper limits.
    press(0);
    press(1);
    frame();
    release_key(0);
    press(3);
    repeat (350) frame();
    release_key(3);
    release_key(1);

    // Last byte of a make code coincides with Frame_Start.
    send_byte(8'hE0);
    nax = axis_model(m_ax, m_keys[2], m_keys[3], X_MAX);
    nay = axis_model(m_ay, m_keys[0], m_keys[1], Y_MAX);
    nbx = axis_model(m_bx, m_keys[2], m_keys[3], X_MAX);
    nby = axis_model(m_by, m_keys[0], m_keys[1], Y_MAX);
    Scan_Valid  = 1'b1;
    Scan_Code   = 8'h74;
    Frame_Start = 1'b1;
    tick();
    Scan_Valid  = 1'b0;
    Frame_Start = 1'b0;
    check_frame(nax, nay, nbx, nby);
    m_keys[3] = 1'b1;
    check_keys("simul");
    frame();
    release_key(3);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 8))
        0, 1: press($urandom_range(0, 3));
        2:    release_key($urandom_range(0, 3));
        3:    bare_release($urandom_range(0, 3));
        4: begin
          do c = 8'($urandom); while (c == 8'hF0 || c == 8'h75 || c == 8'h72 ||
                                      c == 8'h6B || c == 8'h74);
          send_byte(8'hE0);
          send_byte(c);
          check_keys("ext_other");
        end
        5: begin
          do c = 8'($urandom); while (c == 8'hE0 || c == 8'hF0);
          send_byte(c);
          check_keys("noise");
        end
        default: frame();
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset mid-sequence, with Frame_Start ignored during reset.
    send_byte(8'hE0);
    #3;
    RST = 1'b1;
    Frame_Start = 1'b1;
    #1;
    model_reset();
    check("async/ax", a_x, 400);
    check("async/ay", a_y, 400);
    check("async/bx", b_x, BX_INIT);
    check("async/by", b_y, BY_INIT);
    check("async/upd", a_upd, 1'b0);
    check_keys("async");
    tick();
    tick();
    Frame_Start = 1'b0;
    RST = 1'b0;
    send_byte(8'h75);
    check_keys("async_discard");
    frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
